// File: rtl/jump_encoder.sv
// jump_encoder: converts an absolute byte jump target into the 26-bit J-format
// address field. A request is latched in IDLE, encoded in CALC and presented in
// HOLD until the consumer takes it. Misalignment and region-crossing are
// flagged and counted.
module jump_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inTARGET,
  input  logic [31:0] inPC,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] outADDR,
  output logic        err_align,
  output logic        err_region,
  output logic [15:0] req_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] target_q;
  logic [3:0]  pc_region_q;
  logic [25:0] addr_q;
  logic        align_q;
  logic        region_q;
  logic [15:0] req_cnt_q;
  logic [7:0]  err_cnt_q;

  logic        accept;
  logic        calc_align;
  logic        calc_region;

  // Only the region nibble of the PC matters; the low bits are intentionally dropped.
  logic        unused_pc_bits;
  assign unused_pc_bits = ^inPC[27:0];

  assign accept      = (state_q == IDLE) && in_valid;
  assign calc_align  = |target_q[1:0];
  assign calc_region = (target_q[31:28] != pc_region_q);

  // Next-state and handshake outputs for the IDLE/CALC/HOLD sequence.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight request without a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture and encoding; results are frozen outside CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      pc_region_q <= '0;
      addr_q      <= '0;
      align_q     <= 1'b0;
      region_q    <= 1'b0;
    end else begin
      if (accept) begin
        target_q    <= inTARGET;
        pc_region_q <= inPC[31:28];
      end
      if (state_q == CALC) begin
        addr_q   <= target_q[27:2];
        align_q  <= calc_align;
        region_q <= calc_region;
      end
    end
  end

  // Request counter wraps; error counter saturates and counts once per request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (accept) req_cnt_q <= req_cnt_q + 16'd1;
      if ((state_q == CALC) && (calc_align || calc_region) && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign outADDR    = addr_q;
  assign err_align  = align_q;
  assign err_region = region_q;
  assign req_count  = req_cnt_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_jump_encoder.sv
// Directed bench for jump_encoder: the driver pushes expected results into a
// scoreboard queue; an independent monitor pops and compares on each handshake.
module tb_jump_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inTARGET;
  logic [31:0] inPC;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] outADDR;
  logic        err_align;
  logic        err_region;
  logic [15:0] req_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [25:0] addr;
    logic        al;
    logic        rg;
  } exp_t;

  exp_t sb_q[$];

  jump_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inTARGET   (inTARGET),
    .inPC       (inPC),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outADDR    (outADDR),
    .err_align  (err_align),
    .err_region (err_region),
    .req_count  (req_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every completed output handshake against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=0x%0h required=none", outADDR);
      end else begin
        e = sb_q.pop_front();
        $display("result addr=0x%07h align=%0b region=%0b", outADDR, err_align, err_region);
        check("result_addr",   32'(outADDR),    32'(e.addr));
        check("result_align",  32'(err_align),  32'(e.al));
        check("result_region", 32'(err_region), 32'(e.rg));
      end
    end
  end

  // Called shortly after a rising edge; issues one request once in_ready is seen.
  task automatic send(input logic [31:0] t, input logic [31:0] p,
                      input logic [25:0] a, input logic al, input logic rg);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      inTARGET = t;
      inPC     = p;
      in_valid = 1'b1;
      sb_q.push_back(exp_t'({a, al, rg}));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    inTARGET  = '0;
    inPC      = '0;
    #2;
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_addr",      32'(outADDR),   0);
    check("rst_req_count", 32'(req_count), 0);
    check("rst_err_count", 32'(err_count), 0);
    step(2);
    rst = 1'b0;
    step(1);

    // Basic aligned, in-region target with latency check.
    send(32'h00400100, 32'h00400000, 26'h0100040, 1'b0, 1'b0);
    check("lat_calc_out_valid", 32'(out_valid), 0);
    check("lat_calc_in_ready",  32'(in_ready),  0);
    step(1);
    check("lat_hold_out_valid", 32'(out_valid), 1);
    check("t1_req_count",       32'(req_count), 1);
    check("t1_err_count",       32'(err_count), 0);
    step(1);
    check("t1_back_idle",       32'(in_ready),  1);

    // Misaligned target.
    send(32'h00400102, 32'h00400000, 26'h0100040, 1'b1, 1'b0);
    step(2);
    check("t2_err_count", 32'(err_count), 1);
    check("t2_req_count", 32'(req_count), 2);

    // Region crossing, then region crossing plus misalignment.
    send(32'h20000000, 32'h10000000, 26'h0000000, 1'b0, 1'b1);
    step(2);
    check("t3_err_count", 32'(err_count), 2);
    send(32'h20000003, 32'h10000000, 26'h0000000, 1'b1, 1'b1);
    step(2);
    check("t4_err_count", 32'(err_count), 3);
    check("t4_req_count", 32'(req_count), 4);

    // Back-pressure in HOLD with inputs churning.
    out_ready = 1'b0;
    send(32'h0ABCDEF0, 32'h00000000, 26'h2AF37BC, 1'b0, 1'b0);
    step(1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      inTARGET = $urandom;
      inPC     = $urandom;
      step(1);
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_addr",      32'(outADDR),   32'h02AF37BC);
      check("hold_align",     32'(err_align), 0);
      check("hold_in_ready",  32'(in_ready),  0);
      check("hold_req_count", 32'(req_count), 5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(1);
    check("release_in_ready",  32'(in_ready),  1);
    check("release_out_valid", 32'(out_valid), 0);
    check("idle_addr_held",    32'(outADDR),   32'h02AF37BC);
    check("t5_err_count",      32'(err_count), 3);

    // Reset while in CALC: everything clears at once and the result is dropped.
    send(32'h00400100, 32'h00400000, 26'h0100040, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    void'(sb_q.pop_back());
    check("mrst_out_valid", 32'(out_valid), 0);
    check("mrst_in_ready",  32'(in_ready),  1);
    check("mrst_req_count", 32'(req_count), 0);
    check("mrst_err_count", 32'(err_count), 0);
    check("mrst_addr",      32'(outADDR),   0);
    step(1);
    rst = 1'b0;
    step(4);
    check("mrst_no_result", 32'(out_valid), 0);

    // 300 back-to-back misaligned requests: error counter saturates.
    for (int i = 0; i < 300; i++) begin
      t = 32'h00400001 | (32'(i) << 2);
      send(t, 32'h00400000, 26'(32'h00100000 + i), 1'b1, 1'b0);
    end
    step(3);
    check("bulk_req_count", 32'(req_count), 32'h012C);
    check("bulk_err_count", 32'(err_count), 32'hFF);
    check("sb_empty",       32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
